// File: rtl/card_dealer_pkg.sv
// rtl/card_dealer_pkg.sv - shared card types, slot indices and scoring helpers
package card_pkg;

    typedef logic [3:0] card_t;

    localparam card_t CARD_EMPTY = 4'd0;
    localparam card_t CARD_ACE   = 4'd1;
    localparam card_t CARD_KING  = 4'd13;

    localparam int NUM_SLOTS = 6;

    localparam logic [2:0] SLOT_P1 = 3'd0;
    localparam logic [2:0] SLOT_P2 = 3'd1;
    localparam logic [2:0] SLOT_P3 = 3'd2;
    localparam logic [2:0] SLOT_D1 = 3'd3;
    localparam logic [2:0] SLOT_D2 = 3'd4;
    localparam logic [2:0] SLOT_D3 = 3'd5;

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } deal_state_t;

    // Tens and face cards count as zero in baccarat
    function automatic logic [3:0] card_value(input card_t c);
        if (c >= CARD_ACE && c <= 4'd9) begin
            return c;
        end
        return 4'd0;
    endfunction

    function automatic logic [3:0] hand_score(input card_t a, input card_t b, input card_t c);
        logic [4:0] sum;
        sum = {1'b0, card_value(a)} + {1'b0, card_value(b)} + {1'b0, card_value(c)};
        if (sum >= 5'd20) begin
            sum = sum - 5'd20;
        end else if (sum >= 5'd10) begin
            sum = sum - 5'd10;
        end
        return sum[3:0];
    endfunction

endpackage

// File: rtl/card_dealer_if.sv
// rtl/card_dealer_if.sv - deal request/response handshake bundle
interface card_dealer_if;
    import card_pkg::*;

    logic       deal_valid;
    logic [2:0] deal_slot;
    logic       deal_ready;
    logic       deal_done;
    logic       deal_err;
    card_t      dealt_card;

    modport master (
        output deal_valid,
        output deal_slot,
        input  deal_ready,
        input  deal_done,
        input  deal_err,
        input  dealt_card
    );

    modport slave (
        input  deal_valid,
        input  deal_slot,
        output deal_ready,
        output deal_done,
        output deal_err,
        output dealt_card
    );

endinterface

// File: rtl/card_counter.sv
// rtl/card_counter.sv - free-running 1..13 card source, never produces an empty code
module card_counter
    import card_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    output card_t card
);

    card_t card_q;
    card_t card_d;

    always_comb begin
        card_d = (card_q == CARD_KING) ? CARD_ACE : card_q + 4'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            card_q <= CARD_ACE;
        end else begin
            card_q <= card_d;
        end
    end

    assign card = card_q;

endmodule

// File: rtl/card_dealer.sv
// rtl/card_dealer.sv - samples the card counter into player/dealer slots and keeps hand scores
module card_dealer
    import card_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          new_round,
    card_dealer_if.slave  deal,
    output card_t         pcard1,
    output card_t         pcard2,
    output card_t         pcard3,
    output card_t         dcard1,
    output card_t         dcard2,
    output card_t         dcard3,
    output logic [3:0]    pscore,
    output logic [3:0]    dscore
);

    card_t       counter_card;
    deal_state_t state_q, state_d;
    card_t       hold_card_q, hold_card_d;
    logic [2:0]  hold_slot_q, hold_slot_d;
    card_t       dealt_card_q, dealt_card_d;
    card_t       slots_q [NUM_SLOTS];
    card_t       slots_d [NUM_SLOTS];
    logic [3:0]  pscore_q, pscore_d;
    logic [3:0]  dscore_q, dscore_d;
    logic        target_empty;
    logic        write_ok;

    card_counter u_counter (
        .clk   (clk),
        .reset (reset),
        .card  (counter_card)
    );

    // Slot indices 6 and 7 match no entry, so they are never "empty"
    always_comb begin
        target_empty = 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (hold_slot_q == 3'(i)) begin
                target_empty = (slots_q[i] == CARD_EMPTY);
            end
        end
        write_ok = target_empty;
    end

    always_comb begin
        state_d         = state_q;
        hold_card_d     = hold_card_q;
        hold_slot_d     = hold_slot_q;
        dealt_card_d    = dealt_card_q;
        slots_d         = slots_q;
        deal.deal_ready = 1'b0;
        deal.deal_done  = 1'b0;
        deal.deal_err   = 1'b0;

        case (state_q)
            IDLE: begin
                deal.deal_ready = 1'b1;
                if (deal.deal_valid) begin
                    hold_card_d = counter_card;
                    hold_slot_d = deal.deal_slot;
                    state_d     = WRITE;
                end
            end
            WRITE: begin
                deal.deal_done = 1'b1;
                deal.deal_err  = ~write_ok;
                dealt_card_d   = hold_card_q;
                for (int i = 0; i < NUM_SLOTS; i++) begin
                    if (write_ok && hold_slot_q == 3'(i)) begin
                        slots_d[i] = hold_card_q;
                    end
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // new_round discards any pending write; dealt_card keeps its last value
        if (new_round) begin
            state_d        = IDLE;
            dealt_card_d   = dealt_card_q;
            deal.deal_done = 1'b0;
            deal.deal_err  = 1'b0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                slots_d[i] = CARD_EMPTY;
            end
        end
    end

    always_comb begin
        pscore_d = hand_score(slots_q[SLOT_P1], slots_q[SLOT_P2], slots_q[SLOT_P3]);
        dscore_d = hand_score(slots_q[SLOT_D1], slots_q[SLOT_D2], slots_q[SLOT_D3]);
        if (new_round) begin
            pscore_d = 4'd0;
            dscore_d = 4'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            hold_card_q  <= CARD_EMPTY;
            hold_slot_q  <= 3'd0;
            dealt_card_q <= CARD_EMPTY;
            pscore_q     <= 4'd0;
            dscore_q     <= 4'd0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                slots_q[i] <= CARD_EMPTY;
            end
        end else begin
            state_q      <= state_d;
            hold_card_q  <= hold_card_d;
            hold_slot_q  <= hold_slot_d;
            dealt_card_q <= dealt_card_d;
            pscore_q     <= pscore_d;
            dscore_q     <= dscore_d;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                slots_q[i] <= slots_d[i];
            end
        end
    end

    assign deal.dealt_card = dealt_card_q;
    assign pcard1          = slots_q[SLOT_P1];
    assign pcard2          = slots_q[SLOT_P2];
    assign pcard3          = slots_q[SLOT_P3];
    assign dcard1          = slots_q[SLOT_D1];
    assign dcard2          = slots_q[SLOT_D2];
    assign dcard3          = slots_q[SLOT_D3];
    assign pscore          = pscore_q;
    assign dscore          = dscore_q;

endmodule
